// File: rtl/icon_engine_pkg.sv
// Shared constants and types for the icon overlay engine.
package icon_engine_pkg;

  // Per-icon rotation codes, clockwise.
  typedef enum logic [1:0] {
    ORIENT_0   = 2'd0,
    ORIENT_90  = 2'd1,
    ORIENT_180 = 2'd2,
    ORIENT_270 = 2'd3
  } orient_e;

  localparam int unsigned TRANSPARENT_COLOR = 0;
  localparam int unsigned PIPE_LATENCY      = 3;
  localparam int unsigned FRAME_W           = 8;
  localparam int unsigned COORD_W           = 10;
  localparam int unsigned BOUND_W           = 11;

  // Icon index width; a single icon still gets a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icon_engine_if.sv
// Pixel-stream bus: raster position in, icon colour/hit/id out.
interface icon_engine_if #(
  parameter int unsigned COLOR_W = 12,
  parameter int unsigned ID_W    = 2
);
  logic [9:0]         pixCol;
  logic [9:0]         pixRow;
  logic               pixValid;
  logic [COLOR_W-1:0] iconColor;
  logic               iconHit;
  logic [ID_W-1:0]    iconId;

  modport master (
    output pixCol, pixRow, pixValid,
    input  iconColor, iconHit, iconId
  );

  modport slave (
    input  pixCol, pixRow, pixValid,
    output iconColor, iconHit, iconId
  );
endinterface

// File: rtl/icon_engine_rom.sv
// Icon bitmap ROM, synchronous read with one clock of latency.
// Contents are an address-derived pattern (word = address + 1) with the
// bottom-right texel of every icon transparent, so no image file is needed.
module icon_rom #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = 10,
  parameter int unsigned LOC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] data_q;

  function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] a);
    logic [WIDTH-1:0] w;
    w = WIDTH'(a) + WIDTH'(1);
    if (32'(a) >= DEPTH || a[LOC_W-1:0] == '1) w = '0;
    return w;
  endfunction

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= rom_word(addr_i);
  end

  assign rdata_o = data_q;

endmodule

// File: rtl/icon_engine.sv
// Icon overlay engine: priority hit test, rotation, ROM lookup, 3-clock pipe.
module icon_engine
  import icon_engine_pkg::*;
#(
  parameter int unsigned NUM_ICONS   = 4,
  parameter int unsigned ICON_LOG2   = 4,
  parameter int unsigned COLOR_W     = 12,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned BLINK_BIT   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  icon_engine_if.slave           bus,
  input  logic [NUM_ICONS*8-1:0] locX,
  input  logic [NUM_ICONS*8-1:0] locY,
  input  logic [NUM_ICONS*2-1:0] orient,
  input  logic [NUM_ICONS-1:0]   iconEn,
  input  logic [NUM_ICONS-1:0]   blinkEn
);

  localparam int unsigned ICON_W = 2 ** ICON_LOG2;
  localparam int unsigned ID_W   = id_width(NUM_ICONS);
  localparam int unsigned LOC_W  = 2 * ICON_LOG2;
  localparam int unsigned AW     = ID_W + LOC_W;
  localparam int unsigned DEPTH  = NUM_ICONS * ICON_W * ICON_W;

  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 blink;
  logic [BOUND_W-1:0]   px, py, x0, y0, dx, dy;
  logic                 hit_d;
  logic [ID_W-1:0]      id_d;
  logic [ICON_LOG2-1:0] lx_sel, ly_sel, rom_x, rom_y;
  orient_e              ori_sel;
  logic [AW-1:0]        addr_d;

  logic                 hit1_q, hit2_q, hit_q;
  logic [ID_W-1:0]      id1_q, id2_q, id_q;
  logic [AW-1:0]        addr1_q;
  logic [COLOR_W-1:0]   rom_data, color_q;

  assign px    = BOUND_W'(bus.pixCol);
  assign py    = BOUND_W'(bus.pixRow);
  assign blink = frame_q[BLINK_BIT];

  // Frame counter advances on the first active pixel of each frame.
  always_comb begin
    frame_d = frame_q;
    if (bus.pixValid && bus.pixCol == COORD_W'(0) && bus.pixRow == COORD_W'(0))
      frame_d = frame_q + FRAME_W'(1);
  end

  // Priority hit test: scan high to low so the lowest index wins.
  // 11-bit compares keep icons near column/row 1023 clipped, not wrapped.
  always_comb begin
    hit_d   = 1'b0;
    id_d    = '0;
    lx_sel  = '0;
    ly_sel  = '0;
    ori_sel = ORIENT_0;
    x0      = '0;
    y0      = '0;
    dx      = '0;
    dy      = '0;
    for (int i = int'(NUM_ICONS) - 1; i >= 0; i--) begin
      x0 = BOUND_W'(locX[8*i +: 8]) << SCALE_SHIFT;
      y0 = BOUND_W'(locY[8*i +: 8]) << SCALE_SHIFT;
      dx = px - x0;
      dy = py - y0;
      if (bus.pixValid && iconEn[i] && !(blinkEn[i] && blink) &&
          px >= x0 && py >= y0 &&
          dx < BOUND_W'(ICON_W) && dy < BOUND_W'(ICON_W)) begin
        hit_d   = 1'b1;
        id_d    = ID_W'(i);
        lx_sel  = dx[ICON_LOG2-1:0];
        ly_sel  = dy[ICON_LOG2-1:0];
        ori_sel = orient_e'(orient[2*i +: 2]);
      end
    end
  end

  // Rotate local coordinates into ROM coordinates (~v is W-1-v).
  always_comb begin
    rom_x = lx_sel;
    rom_y = ly_sel;
    case (ori_sel)
      ORIENT_90:  begin rom_x = ly_sel;  rom_y = ~lx_sel; end
      ORIENT_180: begin rom_x = ~lx_sel; rom_y = ~ly_sel; end
      ORIENT_270: begin rom_x = ~ly_sel; rom_y = lx_sel;  end
      default:    begin rom_x = lx_sel;  rom_y = ly_sel;  end
    endcase
    addr_d = {id_d, rom_y, rom_x};
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) frame_q <= '0;
    else          frame_q <= frame_d;
  end

  // Stage 1: winning icon and ROM address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit1_q  <= 1'b0;
      id1_q   <= '0;
      addr1_q <= '0;
    end else begin
      hit1_q  <= hit_d;
      id1_q   <= id_d;
      addr1_q <= addr_d;
    end
  end

  icon_rom #(
    .DEPTH (DEPTH),
    .WIDTH (COLOR_W),
    .AW    (AW),
    .LOC_W (LOC_W)
  ) u_rom (
    .clk     (clk),
    .rst_n   (reset_n),
    .addr_i  (addr1_q),
    .rdata_o (rom_data)
  );

  // Stage 2: carry hit/id alongside the ROM read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit2_q <= 1'b0;
      id2_q  <= '0;
    end else begin
      hit2_q <= hit1_q;
      id2_q  <= id1_q;
    end
  end

  // Stage 3: a transparent texel blanks the pixel; no fall-through.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      color_q <= '0;
      hit_q   <= 1'b0;
      id_q    <= '0;
    end else if (hit2_q && rom_data != COLOR_W'(TRANSPARENT_COLOR)) begin
      color_q <= rom_data;
      hit_q   <= 1'b1;
      id_q    <= id2_q;
    end else begin
      color_q <= COLOR_W'(TRANSPARENT_COLOR);
      hit_q   <= 1'b0;
      id_q    <= '0;
    end
  end

  assign bus.iconColor = color_q;
  assign bus.iconHit   = hit_q;
  assign bus.iconId    = id_q;

endmodule

// File: tb/tb_icon_engine.sv
// Bench for icon_engine: vector table plus blink and reset sequences,
// checked through a latency-aligned expectation queue.
module tb_icon_engine;
  import icon_engine_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] locX, locY;
  logic [7:0]  orient;
  logic [3:0]  iconEn, blinkEn;

  icon_engine_if #(.COLOR_W(12), .ID_W(2)) bus ();

  icon_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .locX    (locX),
    .locY    (locY),
    .orient  (orient),
    .iconEn  (iconEn),
    .blinkEn (blinkEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] color;
    logic        hit;
    logic [1:0]  id;
    string       tag;
  } exp_t;

  typedef struct {
    int          col;
    int          row;
    logic        valid;
    logic [3:0]  en;
    logic [7:0]  ori;
    int          color;
    int          id;
    string       tag;
  } vec_t;

  localparam int N_VEC = 20;

  exp_t q[$];
  vec_t tbl[N_VEC];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(input int color, input int id, input string tag);
    exp_t r;
    r.color = 12'(color);
    r.hit   = (color != 0);
    r.id    = 2'(id);
    r.tag   = tag;
    return r;
  endfunction

  function automatic vec_t v(input int col, input int row, input logic valid,
                             input logic [3:0] en, input logic [7:0] ori,
                             input int color, input int id, input string tag);
    vec_t r;
    r.col = col; r.row = row; r.valid = valid; r.en = en; r.ori = ori;
    r.color = color; r.id = id; r.tag = tag;
    return r;
  endfunction

  task automatic check(input exp_t e);
    n_cmp++;
    if (bus.iconColor !== e.color || bus.iconHit !== e.hit || bus.iconId !== e.id) begin
      n_bad++;
      $display("FAIL %s: got color=%0d hit=%0b id=%0d, want color=%0d hit=%0b id=%0d",
               e.tag, bus.iconColor, bus.iconHit, bus.iconId, e.color, e.hit, e.id);
    end
  endtask

  task automatic drive(input int col, input int row, input logic valid);
    bus.pixCol   = 10'(col);
    bus.pixRow   = 10'(row);
    bus.pixValid = valid;
  endtask

  // One clock: record what the current inputs must produce, then check
  // the output that has just emerged from the pipeline.
  task automatic step(input exp_t e);
    exp_t x;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      for (int k = 0; k < int'(PIPE_LATENCY) - 1; k++) q.push_back(mk(0, 0, "flushed"));
      #1;
      check(mk(0, 0, "reset"));
    end else begin
      q.push_back(e);
      #1;
      if (q.size() >= int'(PIPE_LATENCY)) begin
        x = q.pop_front();
        check(x);
      end
    end
  endtask

  initial begin
    // Icons 0,1 at (10,20)->(40,80); icon 2 at (255,50)->(1020,200); icon 3 at (100,100)->(400,400).
    locX    = {8'd100, 8'd255, 8'd10, 8'd10};
    locY    = {8'd100, 8'd50,  8'd20, 8'd20};
    orient  = 8'h00;
    iconEn  = 4'hF;
    blinkEn = 4'h0;
    reset_n = 1'b0;
    drive(0, 0, 1'b0);

    tbl[0]  = v(40,   80,  1'b1, 4'hF, 8'h00, 1,   0, "origin_tl");
    tbl[1]  = v(39,   80,  1'b1, 4'hF, 8'h00, 0,   0, "left_of_icon");
    tbl[2]  = v(45,   85,  1'b1, 4'hF, 8'h00, 86,  0, "overlap_low_wins");
    tbl[3]  = v(45,   85,  1'b1, 4'hE, 8'h00, 342, 1, "overlap_en0_off");
    tbl[4]  = v(45,   85,  1'b0, 4'hF, 8'h00, 0,   0, "pix_invalid");
    tbl[5]  = v(55,   95,  1'b1, 4'hF, 8'h00, 0,   0, "transparent_no_fall");
    tbl[6]  = v(56,   80,  1'b1, 4'hF, 8'h00, 0,   0, "right_edge_out");
    tbl[7]  = v(55,   80,  1'b1, 4'hF, 8'h00, 16,  0, "right_edge_in");
    tbl[8]  = v(40,   96,  1'b1, 4'hF, 8'h00, 0,   0, "bottom_edge_out");
    tbl[9]  = v(40,   95,  1'b1, 4'hF, 8'h00, 241, 0, "bottom_edge_in");
    tbl[10] = v(1020, 200, 1'b1, 4'hF, 8'h00, 513, 2, "clip_first_col");
    tbl[11] = v(1023, 205, 1'b1, 4'hF, 8'h00, 596, 2, "clip_last_col");
    tbl[12] = v(0,    200, 1'b1, 4'hF, 8'h00, 0,   0, "no_wrap_col0");
    tbl[13] = v(11,   200, 1'b1, 4'hF, 8'h00, 0,   0, "no_wrap_col11");
    tbl[14] = v(403,  405, 1'b1, 4'hF, 8'h00, 852, 3, "orient0");
    tbl[15] = v(403,  405, 1'b1, 4'hF, 8'h40, 966, 3, "orient90");
    tbl[16] = v(403,  405, 1'b1, 4'hF, 8'h80, 941, 3, "orient180");
    tbl[17] = v(403,  405, 1'b1, 4'hF, 8'hC0, 827, 3, "orient270");
    tbl[18] = v(403,  405, 1'b1, 4'h7, 8'hC0, 0,   0, "icon3_disabled");
    tbl[19] = v(1021, 203, 1'b1, 4'hB, 8'h00, 0,   0, "icon2_disabled");

    // Reset state.
    step(mk(0, 0, "reset"));
    step(mk(0, 0, "reset"));
    reset_n = 1'b1;

    // Back-to-back vectors; config changes apply to the very next pixel.
    for (int i = 0; i < N_VEC; i++) begin
      iconEn = tbl[i].en;
      orient = tbl[i].ori;
      drive(tbl[i].col, tbl[i].row, tbl[i].valid);
      step(mk(tbl[i].color, tbl[i].id, tbl[i].tag));
    end

    // Blink: phase is frame counter bit 4, counter counts (0,0) pixels.
    iconEn  = 4'h1;
    blinkEn = 4'h1;
    orient  = 8'h00;
    for (int p = 0; p <= 256; p++) begin
      if (p == 0 || p == 15 || p == 32 || p == 256) begin
        drive(40, 80, 1'b1);
        step(mk(1, 0, $sformatf("blink_visible_%0d", p)));
      end else if (p == 16 || p == 31 || p == 255) begin
        drive(40, 80, 1'b1);
        step(mk(0, 0, $sformatf("blink_hidden_%0d", p)));
      end
      if (p < 256) begin
        drive(0, 0, 1'b1);
        step(mk(0, 0, "frame_start"));
      end
    end

    // Mid-icon reset: zero next clock, hits resume three clocks after release.
    blinkEn = 4'h0;
    drive(45, 85, 1'b1);
    for (int k = 0; k < 4; k++) step(mk(86, 0, "pre_reset_hit"));
    reset_n = 1'b0;
    step(mk(0, 0, "reset"));
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(mk(86, 0, "post_reset_hit"));

    // Drain the pipeline.
    drive(0, 0, 1'b0);
    for (int k = 0; k < 3; k++) step(mk(0, 0, "idle"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icon_engine.md
ICON_ENGINE -- requirements
Module: icon_engine

Interface
REQ-001 SHALL have parameter NUM_ICONS, default 4, number of independently placed icons.
REQ-002 SHALL have parameter ICON_LOG2, default 4, icon edge = 2**ICON_LOG2 pixels.
REQ-003 SHALL have parameter COLOR_W, default 12, pixel colour width.
REQ-004 SHALL have parameter SCALE_SHIFT, default 2, world-to-screen shift (screen origin = loc << SCALE_SHIFT).
REQ-005 SHALL have parameter BLINK_BIT, default 4, frame-counter bit driving blink phase.
REQ-006 clk  input  1  system clock; all logic rising-edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 pixCol  input  10  current pixel column.
REQ-009 pixRow  input  10  current pixel row.
REQ-010 pixValid  input  1  high in active video area.
REQ-011 locX  input  NUM_ICONS*8  packed world X of each icon top-left, icon i at bits [8i+7:8i].
REQ-012 locY  input  NUM_ICONS*8  packed world Y, same packing.
REQ-013 orient  input  NUM_ICONS*2  per-icon rotation: 0=0deg, 1=90, 2=180, 3=270.
REQ-014 iconEn  input  NUM_ICONS  per-icon enable.
REQ-015 blinkEn  input  NUM_ICONS  per-icon blink enable.
REQ-016 iconColor  output  COLOR_W  colour to paint; 0 = transparent.
REQ-017 iconHit  output  1  high when iconColor is an opaque icon pixel.
REQ-018 iconId  output  clog2(NUM_ICONS)  index of icon supplying iconColor; 0 when iconHit low.

Function
REQ-019 Icon i SHALL cover screen columns [X0, X0+2**ICON_LOG2-1], X0 = locX_i << SCALE_SHIFT, rows likewise from locY_i.
REQ-020 Bounds compares SHALL use 11-bit arithmetic; icons extending past column/row 1023 SHALL clip, never wrap to column 0.
REQ-021 Local coordinates (lx, ly) = pixel minus X0/Y0, each ICON_LOG2 bits, using both X and Y origins independently.
REQ-022 Rotation SHALL map (lx, ly) to ROM coordinate: 0 -> (lx,ly); 1 -> (ly, W-1-lx); 2 -> (W-1-lx, W-1-ly); 3 -> (W-1-ly, lx), W = 2**ICON_LOG2.
REQ-023 Candidate icon SHALL require pixValid, iconEn_i, in-bounds, and not (blinkEn_i and blink phase = 1).
REQ-024 Among overlapping candidates, lowest index SHALL win.
REQ-025 ROM address SHALL be {winning id, romY, romX}; depth NUM_ICONS * W * W.
REQ-026 Pipeline: stage 1 registers hit/id/address; stage 2 ROM synchronous read; stage 3 registers outputs. Latency SHALL be exactly 3 clocks from pixCol/pixRow to iconColor/iconHit/iconId.
REQ-027 ROM word 0 SHALL be treated as transparent: iconHit low, iconColor 0, iconId 0, even when in bounds (no fall-through to lower-priority icons).
REQ-028 No candidate SHALL produce iconColor 0, iconHit 0, iconId 0.
REQ-029 Frame counter (8 bits) SHALL increment once per cycle where pixValid=1, pixCol=0, pixRow=0; wraps 255 -> 0; blink phase = counter[BLINK_BIT].
REQ-030 Position/orient/enable changes mid-frame SHALL take effect on the next pixel sampled, no shadow registering.

Reset
REQ-031 While reset_n=0 at a clock edge: all pipeline registers, iconColor, iconHit, iconId and frame counter SHALL clear to 0.
REQ-032 Reset asserted mid-frame SHALL flush pipeline; first non-reset output appears 3 clocks after the first sampled reset_n=1.

Structure
REQ-033 Shared package SHALL hold orientation encodings, transparent colour constant (0) and the pipeline latency constant (3).
REQ-034 ROM SHALL be one sub-module icon_rom (synchronous read, 1-clock latency, parameterised depth/width, init file).

Verification
REQ-035 Icon0 loc (10,20), orient 0: pixel (40,80) -> 3 clocks later address {0,0,0}, iconHit=1 if ROM[0]!=0, iconId=0; pixel (39,80) -> iconHit=0.
REQ-036 Icons 0 and 1 both at (10,20), both opaque: pixel (45,85) -> iconId=0; set iconEn[0]=0 -> iconId=1.
REQ-037 Orient 1, pixel local (lx=3, ly=5), W=16 -> ROM coordinate (x=5, y=12); orient 2 -> (12,10); orient 3 -> (10,3).
REQ-038 locX=255 (X0=1020): pixels 1020-1023 hit; pixel column 0-11 of same row -> iconHit=0 (no wrap).
REQ-039 blinkEn[0]=1, BLINK_BIT=4: after 16 frame starts icon 0 invisible, after 32 visible again; counter 255 -> 0 wrap checked.
REQ-040 Assert reset_n=0 for 1 clock mid-icon: outputs 0 next clock, valid hits resume exactly 3 clocks after release.
